inferno_stick_dir: RTL and testbench

- Converts the four MiSTer analog sticks (left/right stick, players 1 and 2) into 4-bit digital directions for the williams2 core's btn_run_1/2 and btn_aim_1/2 inputs.
- Sits between hps_io and williams2 in the emu top level, clocked by clk_sys (12 MHz).
- Each axis has a threshold-with-hysteresis FSM and a minimum-hold counter. The run directions OR in the digital d-pad, then opposing directions are neutralised (SOCD).

---
 rtl/inferno_joy_pkg.sv | 42 ++++
 rtl/inferno_axis_hyst.sv | 92 +++++++++
 rtl/inferno_stick_dir.sv | 107 ++++++++++
 tb/tb_inferno_stick_dir.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/inferno_joy_pkg.sv
// Shared types and constants for the analog-stick to digital-direction path.
// Direction vectors are ordered {up, down, left, right}.
package inferno_joy_pkg;

  typedef enum logic [1:0] {
    CENTER = 2'd0,
    POS    = 2'd1,
    NEG    = 2'd2
  } axis_state_t;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int DEF_ON_THR   = 48;
  localparam int DEF_OFF_THR  = 32;
  localparam int DEF_HOLD_CYC = 12000;
  localparam int DEF_HOLD_W   = 16;

  localparam int NUM_STICKS = 4;
  localparam int STICK_L1   = 0;
  localparam int STICK_L2   = 1;
  localparam int STICK_R1   = 2;
  localparam int STICK_R2   = 3;

  // Opposing directions cancel each other out.
  function automatic logic [3:0] socd(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[DIR_UP] && d[DIR_DOWN]) begin
      r[DIR_UP]   = 1'b0;
      r[DIR_DOWN] = 1'b0;
    end
    if (d[DIR_LEFT] && d[DIR_RIGHT]) begin
      r[DIR_LEFT]  = 1'b0;
      r[DIR_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/inferno_axis_hyst.sv
// One stick axis: centre/positive/negative hysteresis FSM with a minimum-hold
// counter that keeps a freshly entered direction asserted for HOLD_CYC cycles.
module inferno_axis_hyst
  import inferno_joy_pkg::*;
#(
  parameter int ON_THR   = DEF_ON_THR,
  parameter int OFF_THR  = DEF_OFF_THR,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int HOLD_W   = DEF_HOLD_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clear,
  input  logic signed [7:0] value,
  output logic              pos,
  output logic              neg
);

  // Nine bits so that -128 and the negated thresholds compare without overflow.
  localparam logic signed [8:0] ON_P  = 9'(ON_THR);
  localparam logic signed [8:0] ON_N  = -9'(ON_THR);
  localparam logic signed [8:0] OFF_P = 9'(OFF_THR);
  localparam logic signed [8:0] OFF_N = -9'(OFF_THR);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);

  axis_state_t       state_reg, state_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic signed [8:0] v_ext;
  logic              hold_done;

  assign v_ext     = {value[7], value};
  assign hold_done = (hold_reg == '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= CENTER;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_done ? '0 : hold_reg - HOLD_W'(1);
    if (clear) begin
      state_next = CENTER;
      hold_next  = '0;
    end else begin
      case (state_reg)
        CENTER: begin
          if (v_ext >= ON_P) begin
            state_next = POS;
            hold_next  = HOLD_LOAD;
          end else if (v_ext <= ON_N) begin
            state_next = NEG;
            hold_next  = HOLD_LOAD;
          end
        end
        POS: begin
          if (hold_done) begin
            if (v_ext <= ON_N) begin
              state_next = NEG;
              hold_next  = HOLD_LOAD;
            end else if (v_ext < OFF_P) begin
              state_next = CENTER;
            end
          end
        end
        NEG: begin
          if (hold_done) begin
            if (v_ext >= ON_P) begin
              state_next = POS;
              hold_next  = HOLD_LOAD;
            end else if (v_ext > OFF_N) begin
              state_next = CENTER;
            end
          end
        end
        default: begin
          state_next = CENTER;
          hold_next  = '0;
        end
      endcase
    end
  end

  assign pos = (state_reg == POS);
  assign neg = (state_reg == NEG);

endmodule

// File: rtl/inferno_stick_dir.sv
// Maps the four analog sticks plus both d-pads onto williams2 run/aim inputs.
// Three register stages: input capture, axis FSMs / digital delay, output.
module inferno_stick_dir
  import inferno_joy_pkg::*;
#(
  parameter int ON_THR   = DEF_ON_THR,
  parameter int OFF_THR  = DEF_OFF_THR,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int HOLD_W   = DEF_HOLD_W
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        analog_en,
  input  logic [3:0]  dig_1,
  input  logic [3:0]  dig_2,
  input  logic [15:0] joyL1a,
  input  logic [15:0] joyL2a,
  input  logic [15:0] joyR1a,
  input  logic [15:0] joyR2a,
  output logic [3:0]  run_1,
  output logic [3:0]  run_2,
  output logic [3:0]  aim_1,
  output logic [3:0]  aim_2
);

  logic        en_s1_reg;
  logic [3:0]  dig1_s1_reg, dig2_s1_reg;
  logic [3:0]  dig1_s2_reg, dig2_s2_reg;
  logic [15:0] joy_in     [NUM_STICKS];
  logic [15:0] joy_s1_reg [NUM_STICKS];
  logic [3:0]  stick_dir  [NUM_STICKS];
  logic        axis_clear;

  assign joy_in[STICK_L1] = joyL1a;
  assign joy_in[STICK_L2] = joyL2a;
  assign joy_in[STICK_R1] = joyR1a;
  assign joy_in[STICK_R2] = joyR2a;
  assign axis_clear       = ~en_s1_reg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      en_s1_reg   <= 1'b0;
      dig1_s1_reg <= '0;
      dig2_s1_reg <= '0;
      dig1_s2_reg <= '0;
      dig2_s2_reg <= '0;
      for (int i = 0; i < NUM_STICKS; i++) joy_s1_reg[i] <= '0;
    end else begin
      en_s1_reg   <= analog_en;
      dig1_s1_reg <= dig_1;
      dig2_s1_reg <= dig_2;
      dig1_s2_reg <= dig1_s1_reg;
      dig2_s2_reg <= dig2_s1_reg;
      for (int i = 0; i < NUM_STICKS; i++) joy_s1_reg[i] <= joy_in[i];
    end
  end

  // X in the low byte, Y in the high byte; Y negative means up.
  for (genvar gi = 0; gi < NUM_STICKS; gi++) begin : g_stick
    logic x_pos, x_neg, y_pos, y_neg;

    inferno_axis_hyst #(
      .ON_THR  (ON_THR),
      .OFF_THR (OFF_THR),
      .HOLD_CYC(HOLD_CYC),
      .HOLD_W  (HOLD_W)
    ) u_axis_x (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .clear  (axis_clear),
      .value  (joy_s1_reg[gi][7:0]),
      .pos    (x_pos),
      .neg    (x_neg)
    );

    inferno_axis_hyst #(
      .ON_THR  (ON_THR),
      .OFF_THR (OFF_THR),
      .HOLD_CYC(HOLD_CYC),
      .HOLD_W  (HOLD_W)
    ) u_axis_y (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .clear  (axis_clear),
      .value  (joy_s1_reg[gi][15:8]),
      .pos    (y_pos),
      .neg    (y_neg)
    );

    assign stick_dir[gi] = {y_neg, y_pos, x_neg, x_pos};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      run_1 <= '0;
      run_2 <= '0;
      aim_1 <= '0;
      aim_2 <= '0;
    end else begin
      run_1 <= socd(dig1_s2_reg | stick_dir[STICK_L1]);
      run_2 <= socd(dig2_s2_reg | stick_dir[STICK_L2]);
      aim_1 <= stick_dir[STICK_R1];
      aim_2 <= stick_dir[STICK_R2];
    end
  end

endmodule

// File: tb/tb_inferno_stick_dir.sv
// Directed bench: expectations are queued with the edge at which they must
// appear and compared one cycle-edge at a time against two DUT variants.
module tb_inferno_stick_dir;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        analog_en = 1'b0;
  logic [3:0]  dig_1 = '0, dig_2 = '0;
  logic [15:0] joyL1a = '0, joyL2a = '0, joyR1a = '0, joyR2a = '0;

  logic [3:0] f_run_1, f_run_2, f_aim_1, f_aim_2;
  logic [3:0] l_run_1, l_run_2, l_aim_1, l_aim_2;
  logic [15:0] obs_fast, obs_long;

  assign obs_fast = {f_run_1, f_run_2, f_aim_1, f_aim_2};
  assign obs_long = {l_run_1, l_run_2, l_aim_1, l_aim_2};

  always #5 clk_sys = ~clk_sys;

  inferno_stick_dir #(.HOLD_CYC(4), .HOLD_W(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .analog_en(analog_en),
    .dig_1(dig_1), .dig_2(dig_2),
    .joyL1a(joyL1a), .joyL2a(joyL2a), .joyR1a(joyR1a), .joyR2a(joyR2a),
    .run_1(f_run_1), .run_2(f_run_2), .aim_1(f_aim_1), .aim_2(f_aim_2)
  );

  inferno_stick_dir dut_long (
    .clk_sys(clk_sys), .reset_n(reset_n), .analog_en(analog_en),
    .dig_1(dig_1), .dig_2(dig_2),
    .joyL1a(joyL1a), .joyL2a(joyL2a), .joyR1a(joyR1a), .joyR2a(joyR2a),
    .run_1(l_run_1), .run_2(l_run_2), .aim_1(l_aim_1), .aim_2(l_aim_2)
  );

  typedef struct {
    int unsigned when;
    bit          long_dut;
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed={run1,run2,aim1,aim2}=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_at(input int unsigned when, input bit lng, input string tag,
                           input logic [15:0] exp);
    sb_t e;
    e.when = when; e.long_dut = lng; e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    cyc++;
    #1;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].when == cyc) begin
        $display("[TB] cycle %0d %s dut=%s", cyc, sb_q[i].tag, sb_q[i].long_dut ? "long" : "fast");
        chk(sb_q[i].tag, sb_q[i].long_dut ? obs_long : obs_fast, sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int unsigned n;

  initial begin
    // Async reset before any clock edge.
    #1 reset_n = 1'b0;
    #2;
    chk("reset_fast", obs_fast, 16'h0000);
    chk("reset_long", obs_long, 16'h0000);
    ticks(2);
    reset_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      expect_at(cyc + 1, 1'b0, "idle", 16'h0000);
      tick();
    end
    expect_at(cyc + 1, 1'b1, "idle_long", 16'h0000);
    tick();
    analog_en = 1'b1;
    ticks(3);

    // L1 X enters at exactly ON_THR, then drops below OFF_THR during the hold.
    joyL1a = 16'h0030;
    n = cyc + 1;
    expect_at(n + 1, 1'b0, "l1x_latency", 16'h0000);
    for (int k = 2; k <= 6; k++) expect_at(n + k, 1'b0, "l1x_held", 16'h1000);
    expect_at(n + 7, 1'b0, "l1x_release", 16'h0000);
    tick();
    joyL1a = 16'h001F;
    ticks(8);
    joyL1a = 16'h0000;

    // R2 Y: -128, then into the hysteresis band, then just under ON_THR, then -ON_THR.
    joyR2a = 16'h8000;
    n = cyc + 1;
    expect_at(n + 2, 1'b0, "r2y_min_up", 16'h0008);
    ticks(8);
    joyR2a = 16'h2800;
    n = cyc + 1;
    expect_at(n + 1, 1'b0, "r2y_40_lag", 16'h0008);
    expect_at(n + 2, 1'b0, "r2y_40_center", 16'h0000);
    ticks(3);
    joyR2a = 16'h2F00;
    n = cyc + 1;
    expect_at(n + 2, 1'b0, "r2y_47_center", 16'h0000);
    expect_at(n + 3, 1'b0, "r2y_47_center2", 16'h0000);
    ticks(4);
    joyR2a = 16'hD000;
    n = cyc + 1;
    expect_at(n + 2, 1'b0, "r2y_m48_up", 16'h0008);
    ticks(3);
    joyR2a = 16'h0000;
    expect_at(cyc + 8, 1'b0, "r2y_back_center", 16'h0000);
    ticks(8);

    // Digital up against analog down cancels; removing the d-pad leaves down.
    dig_1  = 4'b1000;
    joyL1a = 16'h6400;
    n = cyc + 1;
    expect_at(n + 2, 1'b0, "socd_neutral", 16'h0000);
    expect_at(n + 3, 1'b0, "socd_neutral2", 16'h0000);
    ticks(4);
    dig_1 = 4'b0000;
    n = cyc + 1;
    expect_at(n + 1, 1'b0, "socd_lag", 16'h0000);
    expect_at(n + 2, 1'b0, "socd_down", 16'h4000);
    ticks(3);
    joyL1a = 16'h0000;
    expect_at(cyc + 6, 1'b0, "l1y_center", 16'h0000);
    ticks(6);

    // analog_en drop clears the right stick; re-enable re-enters with a fresh hold.
    joyR1a = 16'h009C;
    n = cyc + 1;
    expect_at(n + 2, 1'b0, "r1x_left", 16'h0020);
    ticks(8);
    analog_en = 1'b0;
    n = cyc + 1;
    expect_at(n + 1, 1'b0, "en_drop_lag", 16'h0020);
    expect_at(n + 2, 1'b0, "en_drop_clear", 16'h0000);
    ticks(4);
    analog_en = 1'b1;
    n = cyc + 1;
    expect_at(n + 1, 1'b0, "en_rise_lag", 16'h0000);
    for (int k = 2; k <= 6; k++) expect_at(n + k, 1'b0, "en_rise_held", 16'h0020);
    expect_at(n + 7, 1'b0, "en_rise_release", 16'h0000);
    tick();
    joyR1a = 16'h0000;
    ticks(8);

    // Full-length hold variant: async reset in the middle of a hold.
    analog_en = 1'b0;
    ticks(3);
    joyL1a = 16'h0064;
    analog_en = 1'b1;
    n = cyc + 1;
    expect_at(n + 2, 1'b1, "long_enter", 16'h1000);
    ticks(6000);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_long", obs_long, 16'h0000);
    chk("async_reset_fast", obs_fast, 16'h0000);
    ticks(2);
    chk("reset_held_long", obs_long, 16'h0000);
    reset_n = 1'b1;
    n = cyc + 1;
    expect_at(n + 1, 1'b1, "reentry_lag", 16'h0000);
    expect_at(n + 2, 1'b1, "reentry_pos", 16'h1000);
    expect_at(n + 12002, 1'b1, "hold_last", 16'h1000);
    expect_at(n + 12003, 1'b1, "hold_release", 16'h0000);
    ticks(2);
    joyL1a = 16'h0000;
    ticks(12004);

    while (sb_q.size() > 0) begin
      chk({"expired_", sb_q[0].tag}, 16'hXXXX, sb_q[0].exp);
      sb_q.delete(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
